// File: rtl/blob_centroid_if.sv
`default_nettype none
// ============================================================================
// Module      : blob_centroid_if
// Description : Stream and result bundle for blob_centroid.
//               The slave modport belongs to the centroid block. It receives
//               the binned mask stream and drives the per-frame results.
//               The master modport is the opposite view, used by whoever
//               drives the stream and consumes the results.
//               Stream signals:
//                 pixel_data_in  - binned mask pixel
//                 hcount_in      - binned column of the pixel
//                 vcount_in      - binned row of the pixel
//                 data_valid_in  - beat qualifier
//               Result signals:
//                 x_out, y_out, count_out, found_out, centroid_valid_out,
//                 busy_out, bbox_{min,max}_{x,y}_out
// Revision    : 1.0 - initial release
// ============================================================================
interface blob_centroid_if #(
  parameter int HRES = 320,
  parameter int VRES = 180
) ();

  localparam int HWIDTH = $clog2(HRES);
  localparam int VWIDTH = $clog2(VRES);
  localparam int CW     = $clog2(HRES * VRES + 1);

  logic              pixel_data_in;
  logic [HWIDTH-1:0] hcount_in;
  logic [VWIDTH-1:0] vcount_in;
  logic              data_valid_in;

  logic [HWIDTH-1:0] x_out;
  logic [VWIDTH-1:0] y_out;
  logic [CW-1:0]     count_out;
  logic              found_out;
  logic              centroid_valid_out;
  logic              busy_out;
  logic [HWIDTH-1:0] bbox_min_x_out;
  logic [HWIDTH-1:0] bbox_max_x_out;
  logic [VWIDTH-1:0] bbox_min_y_out;
  logic [VWIDTH-1:0] bbox_max_y_out;

  modport slave (
    input  pixel_data_in, hcount_in, vcount_in, data_valid_in,
    output x_out, y_out, count_out, found_out, centroid_valid_out, busy_out,
    output bbox_min_x_out, bbox_max_x_out, bbox_min_y_out, bbox_max_y_out
  );

  modport master (
    output pixel_data_in, hcount_in, vcount_in, data_valid_in,
    input  x_out, y_out, count_out, found_out, centroid_valid_out, busy_out,
    input  bbox_min_x_out, bbox_max_x_out, bbox_min_y_out, bbox_max_y_out
  );

endinterface
`default_nettype wire

// File: rtl/blob_centroid.sv
`default_nettype none
// ============================================================================
// Module      : blob_centroid
// Description : Per-frame pixel count, integer centroid and optional
//               bounding box of the set pixels in a binned 1-bit mask stream.
//               Accumulation runs every beat and never stalls the stream.
//               At frame end the sums are snapshotted. Two restoring
//               dividers then run in parallel, one quotient bit per cycle,
//               to form floor(sum_x/count) and floor(sum_y/count).
//               Ports:
//                 clk_in  - system clock
//                 rst_in  - asynchronous active-high reset
//                 bus     - blob_centroid_if.slave
//                           (mask stream in, results out)
//               Build option:
//                 BLOB_CENTROID_BBOX_EN - when defined, the block tracks
//                 the min/max coordinates of the set pixels. When it is not
//                 defined, the bbox outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module blob_centroid #(
  parameter int HRES      = 320,
  parameter int VRES      = 180,
  parameter int MIN_COUNT = 1
) (
  input  logic           clk_in,
  input  logic           rst_in,
  blob_centroid_if.slave bus
);

  localparam int HWIDTH = $clog2(HRES);
  localparam int VWIDTH = $clog2(VRES);
  localparam int CW     = $clog2(HRES * VRES + 1);
  localparam int SUMW   = $clog2(HRES * HRES * VRES);
  localparam int QW     = (HWIDTH > VWIDTH) ? HWIDTH : VWIDTH;
  // The shifted divisor (count << i) can exceed SUMW bits. The compare is
  // therefore done at full width, so that no high bits are lost.
  localparam int DW     = SUMW + QW;
  localparam int BW     = (QW > 1) ? $clog2(QW) : 1;

  localparam logic [HWIDTH-1:0] C_LAST_H    = HWIDTH'(HRES - 1);
  localparam logic [VWIDTH-1:0] C_LAST_V    = VWIDTH'(VRES - 1);
  localparam logic [CW-1:0]     C_MIN_COUNT = CW'(MIN_COUNT);
  localparam logic [BW-1:0]     C_LAST_BIT  = BW'(QW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_step;

  // --------------------------------------------------------------------------
  // Stream accumulation
  // --------------------------------------------------------------------------
  logic            w_hit;
  logic            w_frame_end;
  logic [CW-1:0]   r_cnt;
  logic [SUMW-1:0] r_sx;
  logic [SUMW-1:0] r_sy;
  logic [CW-1:0]   w_cnt_nxt;
  logic [SUMW-1:0] w_sx_nxt;
  logic [SUMW-1:0] w_sy_nxt;

  assign w_hit       = bus.data_valid_in & bus.pixel_data_in;
  assign w_frame_end = bus.data_valid_in && (bus.hcount_in == C_LAST_H) &&
                       (bus.vcount_in == C_LAST_V);

  // The "next" values include the current beat. The frame-end snapshot
  // therefore captures the last pixel of the frame.
  assign w_cnt_nxt = r_cnt + CW'(w_hit);
  assign w_sx_nxt  = r_sx + (w_hit ? SUMW'(bus.hcount_in) : '0);
  assign w_sy_nxt  = r_sy + (w_hit ? SUMW'(bus.vcount_in) : '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
    end else if (w_frame_end) begin
      // Cleared even when the divider is busy. The next beat belongs to a
      // new frame in every case.
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
    end else if (w_hit) begin
      r_cnt <= w_cnt_nxt;
      r_sx  <= w_sx_nxt;
      r_sy  <= w_sy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  logic [BW-1:0] r_bit;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A frame end that arrives in DIV or DONE is never loaded. Only
        // a frame end seen in IDLE starts a new result.
        if (w_frame_end) begin
          w_load      = 1'b1;
          w_state_nxt = (w_cnt_nxt >= C_MIN_COUNT) ? S_DIV : S_DONE;
        end
      end
      S_DIV: begin
        w_step = 1'b1;
        if (r_bit == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Restoring dividers (x and y share the divisor and the bit counter)
  // --------------------------------------------------------------------------
  logic [CW-1:0]     r_div_cnt;
  logic [SUMW-1:0]   r_rem_x;
  logic [SUMW-1:0]   r_rem_y;
  logic [HWIDTH-1:0] r_q_x;
  logic [VWIDTH-1:0] r_q_y;
  logic              r_found_snap;
  logic [DW-1:0]     w_dsr;
  logic              w_ge_x;
  logic              w_ge_y;

  assign w_dsr  = DW'(r_div_cnt) << r_bit;
  assign w_ge_x = {{QW{1'b0}}, r_rem_x} >= w_dsr;
  assign w_ge_y = {{QW{1'b0}}, r_rem_y} >= w_dsr;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_div_cnt    <= '0;
      r_rem_x      <= '0;
      r_rem_y      <= '0;
      r_q_x        <= '0;
      r_q_y        <= '0;
      r_bit        <= '0;
      r_found_snap <= 1'b0;
    end else if (w_load) begin
      r_div_cnt    <= w_cnt_nxt;
      r_rem_x      <= w_sx_nxt;
      r_rem_y      <= w_sy_nxt;
      r_q_x        <= '0;
      r_q_y        <= '0;
      r_bit        <= C_LAST_BIT;
      r_found_snap <= (w_cnt_nxt >= C_MIN_COUNT);
    end else if (w_step) begin
      // Quotient bits enter MSB first by shifting left. Any bits above an
      // output width are zero, because the centroid lies inside the frame.
      if (w_ge_x) begin
        r_rem_x <= r_rem_x - w_dsr[SUMW-1:0];
      end
      if (w_ge_y) begin
        r_rem_y <= r_rem_y - w_dsr[SUMW-1:0];
      end
      r_q_x <= (r_q_x << 1) | HWIDTH'(w_ge_x);
      r_q_y <= (r_q_y << 1) | VWIDTH'(w_ge_y);
      r_bit <= r_bit - BW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------
  logic [HWIDTH-1:0] r_x_out;
  logic [VWIDTH-1:0] r_y_out;
  logic [CW-1:0]     r_count_out;
  logic              r_found_out;
  logic              r_valid_out;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_count_out <= '0;
      r_found_out <= 1'b0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_count_out <= r_div_cnt;
        r_found_out <= r_found_snap;
        // With no detection, the last good centroid is kept.
        if (r_found_snap) begin
          r_x_out <= r_q_x;
          r_y_out <= r_q_y;
        end
      end
    end
  end

  assign bus.x_out              = r_x_out;
  assign bus.y_out              = r_y_out;
  assign bus.count_out          = r_count_out;
  assign bus.found_out          = r_found_out;
  assign bus.centroid_valid_out = r_valid_out;
  assign bus.busy_out           = (r_state == S_DIV);

  // --------------------------------------------------------------------------
  // Bounding box
  // --------------------------------------------------------------------------
`ifdef BLOB_CENTROID_BBOX_EN
  logic [HWIDTH-1:0] r_min_x, r_max_x, r_snap_min_x, r_snap_max_x;
  logic [VWIDTH-1:0] r_min_y, r_max_y, r_snap_min_y, r_snap_max_y;
  logic [HWIDTH-1:0] r_bbox_min_x, r_bbox_max_x;
  logic [VWIDTH-1:0] r_bbox_min_y, r_bbox_max_y;
  logic [HWIDTH-1:0] w_min_x_nxt, w_max_x_nxt;
  logic [VWIDTH-1:0] w_min_y_nxt, w_max_y_nxt;

  assign w_min_x_nxt = (w_hit && (bus.hcount_in < r_min_x)) ? bus.hcount_in : r_min_x;
  assign w_max_x_nxt = (w_hit && (bus.hcount_in > r_max_x)) ? bus.hcount_in : r_max_x;
  assign w_min_y_nxt = (w_hit && (bus.vcount_in < r_min_y)) ? bus.vcount_in : r_min_y;
  assign w_max_y_nxt = (w_hit && (bus.vcount_in > r_max_y)) ? bus.vcount_in : r_max_y;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_min_x      <= '1;
      r_max_x      <= '0;
      r_min_y      <= '1;
      r_max_y      <= '0;
      r_snap_min_x <= '1;
      r_snap_max_x <= '0;
      r_snap_min_y <= '1;
      r_snap_max_y <= '0;
      r_bbox_min_x <= '0;
      r_bbox_max_x <= '0;
      r_bbox_min_y <= '0;
      r_bbox_max_y <= '0;
    end else begin
      if (w_frame_end) begin
        r_min_x <= '1;
        r_max_x <= '0;
        r_min_y <= '1;
        r_max_y <= '0;
      end else begin
        r_min_x <= w_min_x_nxt;
        r_max_x <= w_max_x_nxt;
        r_min_y <= w_min_y_nxt;
        r_max_y <= w_max_y_nxt;
      end
      if (w_load) begin
        r_snap_min_x <= w_min_x_nxt;
        r_snap_max_x <= w_max_x_nxt;
        r_snap_min_y <= w_min_y_nxt;
        r_snap_max_y <= w_max_y_nxt;
      end
      if (r_state == S_DONE) begin
        r_bbox_min_x <= r_snap_min_x;
        r_bbox_max_x <= r_snap_max_x;
        r_bbox_min_y <= r_snap_min_y;
        r_bbox_max_y <= r_snap_max_y;
      end
    end
  end

  assign bus.bbox_min_x_out = r_bbox_min_x;
  assign bus.bbox_max_x_out = r_bbox_max_x;
  assign bus.bbox_min_y_out = r_bbox_min_y;
  assign bus.bbox_max_y_out = r_bbox_max_y;
`else
  assign bus.bbox_min_x_out = '0;
  assign bus.bbox_max_x_out = '0;
  assign bus.bbox_min_y_out = '0;
  assign bus.bbox_max_y_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blob_centroid.sv
`default_nettype none
// ============================================================================
// Module      : tb_blob_centroid
// Description : Self-checking bench for blob_centroid. It applies a table of
//               sparse frames: set-pixel rectangles, then the frame-end beat.
//               It also runs hand-written sequences for a frame end while
//               the divider is busy, a reset in mid-division, and a full
//               all-ones frame with random idle gaps.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_blob_centroid;

  localparam int HRES = 320;
  localparam int VRES = 180;
  localparam int QW   = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blob_centroid_if #(.HRES(HRES), .VRES(VRES)) bus ();

  blob_centroid #(.HRES(HRES), .VRES(VRES), .MIN_COUNT(1)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct {
    int ax, ay, aw, ah;       // rectangle A of set pixels
    int bx, by, bw, bh;       // rectangle B of set pixels
    int lastp;                // pixel value on the frame-end beat
    int cnt, x, y, found;     // expected results
    int minx, miny, maxx, maxy;
  } vec_t;

  vec_t tbl[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int bb(input int v);
    int r = v;
`ifndef BLOB_CENTROID_BBOX_EN
    r = 0;
`endif
    return r;
  endfunction

  task automatic beat(input bit v, input bit p, input int h, input int vc);
    @(negedge clk);
    bus.data_valid_in = v;
    bus.pixel_data_in = p;
    bus.hcount_in     = 9'(h);
    bus.vcount_in     = 8'(vc);
  endtask

  // Idle beats carry frame-end coordinates with the pixel set. They must be
  // ignored because valid is low.
  task automatic idle_inputs();
    bus.data_valid_in = 1'b0;
    bus.pixel_data_in = 1'b1;
    bus.hcount_in     = 9'(HRES - 1);
    bus.vcount_in     = 8'(VRES - 1);
  endtask

  task automatic drive_frame(input vec_t t);
    for (int yy = t.ay; yy < t.ay + t.ah; yy++)
      for (int xx = t.ax; xx < t.ax + t.aw; xx++)
        beat(1'b1, 1'b1, xx, yy);
    beat(1'b0, 1'b1, HRES - 1, VRES - 1);
    for (int yy = t.by; yy < t.by + t.bh; yy++)
      for (int xx = t.bx; xx < t.bx + t.bw; xx++)
        beat(1'b1, 1'b1, xx, yy);
    beat(1'b1, t.lastp[0], HRES - 1, VRES - 1);
  endtask

  // Called right after the last beat was driven at a negedge. k0 counts the
  // negedges the caller already spent after that beat.
  task automatic wait_result(input int k0, output bit got, output int lat, output int busy_n);
    got = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
      if (bus.busy_out) busy_n++;
      if (bus.centroid_valid_out) begin
        got = 1'b1;
        lat = k - 1 + k0;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t t, input int k0, input int exp_busy);
    bit got;
    int lat, bn;
    wait_result(k0, got, lat, bn);
    check($sformatf("%s pulse_seen", tag), int'(got), 1);
    if (got) begin
      check($sformatf("%s latency", tag), lat, (t.found != 0) ? QW + 1 : 1);
      check($sformatf("%s busy_cycles", tag), bn, exp_busy);
      check($sformatf("%s count", tag), int'(bus.count_out), t.cnt);
      check($sformatf("%s found", tag), int'(bus.found_out), t.found);
      check($sformatf("%s x", tag), int'(bus.x_out), t.x);
      check($sformatf("%s y", tag), int'(bus.y_out), t.y);
      check($sformatf("%s bbox_min_x", tag), int'(bus.bbox_min_x_out), bb(t.minx));
      check($sformatf("%s bbox_min_y", tag), int'(bus.bbox_min_y_out), bb(t.miny));
      check($sformatf("%s bbox_max_x", tag), int'(bus.bbox_max_x_out), bb(t.maxx));
      check($sformatf("%s bbox_max_y", tag), int'(bus.bbox_max_y_out), bb(t.maxy));
      @(negedge clk);
      check($sformatf("%s one_cycle_pulse", tag), int'(bus.centroid_valid_out), 0);
    end
  endtask

  initial begin
    vec_t v;
    int   extra;

    //          A rect          B rect          lastp cnt  x    y   f  minx miny maxx maxy
    tbl[0] = '{10, 20, 1, 1,   0, 0, 0, 0,     0,    1,  10,  20, 1, 10,  20,  10,  20};
    tbl[1] = '{100, 50, 2, 2,  0, 0, 0, 0,     0,    4,  100, 50, 1, 100, 50,  101, 51};
    tbl[2] = '{0, 0, 0, 0,     0, 0, 0, 0,     0,    0,  100, 50, 0, 511, 255, 0,   0};
    tbl[3] = '{0, 0, 0, 0,     0, 0, 0, 0,     1,    1,  319, 179,1, 319, 179, 319, 179};
    tbl[4] = '{5, 7, 1, 1,     300, 170, 1, 1, 0,    2,  152, 88, 1, 5,   7,   300, 170};
    tbl[5] = '{0, 0, 3, 1,     0, 179, 1, 1,   0,    4,  0,   44, 1, 0,   0,   2,   179};

    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset x_out", int'(bus.x_out), 0);
    check("reset y_out", int'(bus.y_out), 0);
    check("reset count_out", int'(bus.count_out), 0);
    check("reset found_out", int'(bus.found_out), 0);
    check("reset valid_out", int'(bus.centroid_valid_out), 0);
    check("reset busy_out", int'(bus.busy_out), 0);
    check("reset bbox_max_x", int'(bus.bbox_max_x_out), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive_frame(tbl[i]);
      check_result($sformatf("vec%0d", i), tbl[i], 0, (tbl[i].found != 0) ? QW : 0);
      repeat (3) @(negedge clk);
    end

    // A frame end arrives while dividing. The in-flight result completes,
    // the new frame produces no pulse, and its pixels are dropped.
    v = '{10, 20, 1, 1, 0, 0, 0, 0, 0, 1, 10, 20, 1, 10, 20, 10, 20};
    drive_frame(v);
    beat(1'b1, 1'b1, 50, 60);
    beat(1'b1, 1'b0, HRES - 1, VRES - 1);
    check_result("busy_overlap", v, 2, QW - 2);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.centroid_valid_out) extra++;
    end
    check("busy_overlap extra_pulses", extra, 0);
    v = '{7, 8, 1, 1, 0, 0, 0, 0, 0, 1, 7, 8, 1, 7, 8, 7, 8};
    drive_frame(v);
    check_result("after_overlap", v, 0, QW);
    repeat (3) @(negedge clk);

    // Reset in mid-division, with a stray pixel already accumulated.
    v = '{200, 100, 1, 1, 0, 0, 0, 0, 0, 1, 200, 100, 1, 200, 100, 200, 100};
    drive_frame(v);
    beat(1'b1, 1'b1, 33, 44);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("midreset x_out", int'(bus.x_out), 0);
    check("midreset y_out", int'(bus.y_out), 0);
    check("midreset count_out", int'(bus.count_out), 0);
    check("midreset found_out", int'(bus.found_out), 0);
    check("midreset busy_out", int'(bus.busy_out), 0);
    check("midreset bbox_max_x", int'(bus.bbox_max_x_out), 0);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.centroid_valid_out) extra++;
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.centroid_valid_out) extra++;
    end
    check("midreset pulses", extra, 0);
    v = '{3, 4, 1, 1, 0, 0, 0, 0, 0, 1, 3, 4, 1, 3, 4, 3, 4};
    drive_frame(v);
    check_result("after_reset", v, 0, QW);
    repeat (3) @(negedge clk);

    // All-ones frame in raster order, with random idle gaps.
    for (int yy = 0; yy < VRES; yy++) begin
      for (int xx = 0; xx < HRES; xx++) begin
        if ($urandom_range(0, 15) == 0)
          beat(1'b0, 1'b1, $urandom_range(0, HRES - 1), $urandom_range(0, VRES - 1));
        beat(1'b1, 1'b1, xx, yy);
      end
    end
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 57600, 159, 89, 1, 0, 0, 319, 179};
    check_result("all_ones", v, 0, QW);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
